// File: rtl/operand_sequencer_pkg.sv
// rtl/operand_sequencer_pkg.sv - shared states, MISR polynomial and default sizes for operand_sequencer
package operand_sequencer_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ZERO,
      S_RUN,
      S_DRAIN
   } seq_state_t;

   localparam logic [11:0] MISR_POLY = 12'h053;

   localparam int DEF_W        = 12;
   localparam int DEF_DEPTH    = 4;
   localparam int DEF_HOLD     = 8;
   localparam int DEF_ZERO_CYC = 1;
   localparam int DEF_LAT      = 2;
   localparam int DEF_PAT_LEN  = 16;

   // wide enough for HOLD, ZERO_CYC and LAT phase counting
   localparam int CNT_W = 8;

endpackage

// File: rtl/operand_sequencer_misr.sv
// rtl/operand_sequencer_misr.sv - result compactor: e delay pipe, W-bit MISR and saturating sample count
module seq_misr
   import operand_sequencer_pkg::*;
#(
   parameter int W   = DEF_W,
   parameter int LAT = DEF_LAT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] y,
   output logic [W-1:0] sig,
   output logic [7:0]   samp_cnt
);

   logic [LAT-1:0] pipe;
   logic           e_d;

   assign e_d = pipe[LAT-1];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         pipe     <= '0;
         sig      <= '0;
         samp_cnt <= '0;
      end else begin
         pipe <= (pipe << 1) | LAT'(en);
         // e_d marks the cycle where the result for an enabled beat sits on y
         if (e_d) begin
            sig      <= {sig[W-2:0], 1'b0} ^ (sig[W-1] ? W'(MISR_POLY) : '0) ^ y;
            samp_cnt <= (samp_cnt == 8'hFF) ? samp_cnt : samp_cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - plays programmed operand triples with an enable pattern and signs the results
module operand_sequencer
   import operand_sequencer_pkg::*;
#(
   parameter int W        = DEF_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int HOLD     = DEF_HOLD,
   parameter int ZERO_CYC = DEF_ZERO_CYC,
   parameter int LAT      = DEF_LAT,
   parameter int PAT_LEN  = DEF_PAT_LEN,
   localparam int AW      = $clog2(DEPTH),
   localparam int BW      = $clog2(PAT_LEN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [AW-1:0]      cfg_addr,
   input  logic [W-1:0]       cfg_a,
   input  logic [W-1:0]       cfg_b,
   input  logic [W-1:0]       cfg_c,
   input  logic [PAT_LEN-1:0] pattern,
   input  logic [AW-1:0]      n_trip,
   input  logic               start,
   input  logic [W-1:0]       y_in,
   output logic [W-1:0]       a,
   output logic [W-1:0]       b,
   output logic [W-1:0]       c,
   output logic               e,
   output logic               busy,
   output logic               done,
   output logic [W-1:0]       sig,
   output logic [7:0]         samp_cnt
);

   logic [W-1:0] slot_a [DEPTH];
   logic [W-1:0] slot_b [DEPTH];
   logic [W-1:0] slot_c [DEPTH];

   seq_state_t         state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [AW-1:0]      trip, trip_n, ntrip_q, ntrip_n;
   logic [BW-1:0]      beat, beat_n, beat_inc;
   logic [PAT_LEN-1:0] pat_q, pat_n;
   logic [W-1:0]       a_n, b_n, c_n;
   logic               e_n, busy_n, done_n, clr;

   always_ff @(posedge clk) begin
      if (state == S_IDLE && cfg_we) begin
         slot_a[cfg_addr] <= cfg_a;
         slot_b[cfg_addr] <= cfg_b;
         slot_c[cfg_addr] <= cfg_c;
      end
   end

   assign beat_inc = (beat == BW'(PAT_LEN - 1)) ? '0 : beat + BW'(1);

   // outputs are computed for the next cycle so a/b/c/e leave the flops aligned with state
   always_comb begin
      state_n = state;
      cnt_n   = cnt + CNT_W'(1);
      trip_n  = trip;
      beat_n  = beat;
      pat_n   = pat_q;
      ntrip_n = ntrip_q;
      a_n     = '0;
      b_n     = '0;
      c_n     = '0;
      e_n     = 1'b0;
      busy_n  = busy;
      done_n  = 1'b0;
      clr     = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_n = '0;
            if (start) begin
               state_n = S_ZERO;
               pat_n   = pattern;
               ntrip_n = n_trip;
               trip_n  = '0;
               beat_n  = '0;
               busy_n  = 1'b1;
               clr     = 1'b1;
            end
         end
         S_ZERO: begin
            if (cnt == CNT_W'(ZERO_CYC - 1)) begin
               state_n = S_RUN;
               cnt_n   = '0;
               a_n     = slot_a[trip];
               b_n     = slot_b[trip];
               c_n     = slot_c[trip];
               e_n     = pat_q[beat];
               beat_n  = beat_inc;
            end
         end
         S_RUN: begin
            if (cnt == CNT_W'(HOLD - 1)) begin
               cnt_n = '0;
               if (trip == ntrip_q) begin
                  state_n = S_DRAIN;
               end else begin
                  state_n = S_ZERO;
                  trip_n  = trip + AW'(1);
               end
            end else begin
               a_n    = slot_a[trip];
               b_n    = slot_b[trip];
               c_n    = slot_c[trip];
               e_n    = pat_q[beat];
               beat_n = beat_inc;
            end
         end
         S_DRAIN: begin
            if (cnt == CNT_W'(LAT - 1)) begin
               state_n = S_IDLE;
               cnt_n   = '0;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         trip    <= '0;
         beat    <= '0;
         pat_q   <= '0;
         ntrip_q <= '0;
         a       <= '0;
         b       <= '0;
         c       <= '0;
         e       <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         trip    <= trip_n;
         beat    <= beat_n;
         pat_q   <= pat_n;
         ntrip_q <= ntrip_n;
         a       <= a_n;
         b       <= b_n;
         c       <= c_n;
         e       <= e_n;
         busy    <= busy_n;
         done    <= done_n;
      end
   end

   seq_misr #(
      .W   (W),
      .LAT (LAT)
   ) u_misr (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .en       (e),
      .y        (y_in),
      .sig      (sig),
      .samp_cnt (samp_cnt)
   );

endmodule

// File: tb/tb_operand_sequencer.sv
// tb/tb_operand_sequencer.sv - directed and randomized runs checked against a trace-level reference model
module tb_operand_sequencer;

   localparam int W     = 12;
   localparam int DEPTH = 4;
   localparam int HOLD  = 8;
   localparam int ZC    = 1;
   localparam int LAT   = 2;
   localparam int PL    = 16;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst, cfg_we, start, e, busy, done;
   logic [AW-1:0] cfg_addr, n_trip;
   logic [W-1:0]  cfg_a, cfg_b, cfg_c, y_in, a, b, c, sig;
   logic [PL-1:0] pattern;
   logic [7:0]    samp_cnt;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] ma [DEPTH];
   logic [W-1:0] mb [DEPTH];
   logic [W-1:0] mc [DEPTH];
   logic [W-1:0] ymem [64];
   logic [W-1:0] ea [64];
   logic [W-1:0] eb [64];
   logic [W-1:0] ec [64];
   logic         ee [64];
   int           elen, ecnt;
   logic [W-1:0] esig;

   logic [W-1:0] r_sig;
   logic [7:0]   r_cnt;
   int           r_busy;

   operand_sequencer #(
      .W(W), .DEPTH(DEPTH), .HOLD(HOLD), .ZERO_CYC(ZC), .LAT(LAT), .PAT_LEN(PL)
   ) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_c(cfg_c), .pattern(pattern),
      .n_trip(n_trip), .start(start), .y_in(y_in), .a(a), .b(b), .c(c),
      .e(e), .busy(busy), .done(done), .sig(sig), .samp_cnt(samp_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic write_slot(input int s, input logic [W-1:0] va, input logic [W-1:0] vb,
                             input logic [W-1:0] vc);
      cfg_we   = 1'b1;
      cfg_addr = s[AW-1:0];
      cfg_a    = va;
      cfg_b    = vb;
      cfg_c    = vc;
      ma[s]    = va;
      mb[s]    = vb;
      mc[s]    = vc;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic fill_y_random();
      for (int i = 0; i < 64; i++) ymem[i] = W'($urandom);
   endtask

   // expected per-cycle trace from busy rising to the last DRAIN cycle, then the signature over it
   task automatic build_model(input logic [PL-1:0] pat, input int ntrip);
      int k = 0;
      int bt = 0;
      int s = 0;
      for (int t = 0; t <= ntrip; t++) begin
         for (int z = 0; z < ZC; z++) begin
            ea[k] = '0; eb[k] = '0; ec[k] = '0; ee[k] = 1'b0; k++;
         end
         for (int h = 0; h < HOLD; h++) begin
            ea[k] = ma[t]; eb[k] = mb[t]; ec[k] = mc[t]; ee[k] = pat[bt % PL];
            bt++; k++;
         end
      end
      for (int d = 0; d < LAT; d++) begin
         ea[k] = '0; eb[k] = '0; ec[k] = '0; ee[k] = 1'b0; k++;
      end
      elen = k;
      ecnt = 0;
      for (int j = LAT; j < elen; j++) begin
         if (ee[j - LAT]) begin
            s = s * 2;
            if (s >= 4096) s = (s - 4096) ^ 'h053;
            s = s ^ int'(ymem[j]);
            ecnt = (ecnt < 255) ? ecnt + 1 : 255;
         end
      end
      esig = W'(s);
   endtask

   task automatic run(input string tag, input logic [PL-1:0] pat, input int ntrip,
                      input bit disturb, input bit wr_start, input int ws,
                      input logic [W-1:0] wa, input logic [W-1:0] wb, input logic [W-1:0] wc);
      r_busy = 0;
      if (wr_start) begin
         ma[ws] = wa; mb[ws] = wb; mc[ws] = wc;
      end
      build_model(pat, ntrip);
      pattern = pat;
      n_trip  = ntrip[AW-1:0];
      start   = 1'b1;
      if (wr_start) begin
         cfg_we = 1'b1; cfg_addr = ws[AW-1:0]; cfg_a = wa; cfg_b = wb; cfg_c = wc;
      end
      step();
      start  = 1'b0;
      cfg_we = 1'b0;
      for (int k = 0; k < elen; k++) begin
         y_in = ymem[k];
         check({tag, "_cycle"}, {25'd0, a, b, c, e, busy, done},
               {25'd0, ea[k], eb[k], ec[k], ee[k], 1'b1, 1'b0});
         if (busy) r_busy++;
         if (disturb && k == 3) begin
            start = 1'b1; cfg_we = 1'b1; cfg_addr = '0;
            cfg_a = ~ma[0]; cfg_b = ~mb[0]; cfg_c = ~mc[0];
            pattern = ~pat; n_trip = ~n_trip;
         end else begin
            start = 1'b0; cfg_we = 1'b0;
         end
         step();
      end
      start  = 1'b0;
      cfg_we = 1'b0;
      check({tag, "_done"}, {62'd0, busy, done}, {62'd0, 1'b0, 1'b1});
      check({tag, "_sig"}, 64'(sig), 64'(esig));
      check({tag, "_cnt"}, 64'(samp_cnt), 64'(ecnt));
      r_sig = sig;
      r_cnt = samp_cnt;
      step();
      check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_a = '0; cfg_b = '0; cfg_c = '0;
      pattern = '0; n_trip = '0; start = 1'b0; y_in = '0;
      step();
      step();
      rst = 1'b0;
      check("reset_state", {5'd0, a, b, c, e, busy, done, sig, samp_cnt}, 64'd0);

      for (int s = 0; s < DEPTH; s++) write_slot(s, W'($urandom), W'($urandom), W'($urandom));

      for (int i = 0; i < 64; i++) ymem[i] = 12'h123;
      run("single", 16'h0001, 0, 1'b0, 1'b0, 0, '0, '0, '0);
      check("single_sig", 64'(r_sig), 64'h123);
      check("single_cnt", 64'(r_cnt), 64'd1);

      fill_y_random();
      ymem[3] = 12'h800;
      ymem[4] = 12'h001;
      run("two", 16'h0003, 0, 1'b0, 1'b0, 0, '0, '0, '0);
      check("two_sig", 64'(r_sig), 64'h052);
      check("two_cnt", 64'(r_cnt), 64'd2);

      write_slot(0, 12'hDFC, 12'h5B4, 12'h0E7);
      write_slot(1, 12'h000, 12'h000, 12'h000);
      fill_y_random();
      run("playback", PL'($urandom), 1, 1'b0, 1'b0, 0, '0, '0, '0);
      check("playback_busy", 64'(r_busy), 64'd20);

      fill_y_random();
      run("alt", 16'hAAAA, 1, 1'b0, 1'b0, 0, '0, '0, '0);
      check("alt_cnt", 64'(r_cnt), 64'd8);

      for (int r = 0; r < 6; r++) begin
         for (int s = 0; s < DEPTH; s++) write_slot(s, W'($urandom), W'($urandom), W'($urandom));
         fill_y_random();
         run("random", PL'($urandom), int'($urandom_range(0, DEPTH - 1)), 1'b0,
             bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
             W'($urandom), W'($urandom), W'($urandom));
      end

      fill_y_random();
      run("busy_req", 16'h0000, 1, 1'b1, 1'b0, 0, '0, '0, '0);
      check("busy_req_sig", 64'(r_sig), 64'd0);
      check("busy_req_cnt", 64'(r_cnt), 64'd0);
      fill_y_random();
      run("readback", PL'($urandom), DEPTH - 1, 1'b0, 1'b0, 0, '0, '0, '0);

      pattern = 16'hFFFF;
      n_trip  = 2'd3;
      start   = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < ZC + 3; k++) begin
         y_in = W'($urandom);
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrun_reset", {5'd0, a, b, c, e, busy, done, sig, samp_cnt}, 64'd0);
      step();
      check("midrun_no_done", {62'd0, busy, done}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
